// File: rtl/fisr_pkg.sv
// Shared types and constants for the fast inverse square root Newton controller.
// Holds the FSM state type, bypass classes, IEEE-754 constants and default timing.
package fisr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL  = 2'd0,
    CLS_TO_PINF = 2'd1,
    CLS_TO_ZERO = 2'd2,
    CLS_TO_QNAN = 2'd3
  } fp_class_e;

  localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF         = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO         = 32'h0000_0000;
  localparam logic [31:0] FP_THREE_HALVES = 32'h3FC0_0000;

  localparam int DEF_PIPE_LAT = 4;
  localparam int DEF_ITERS    = 2;

  // Forced result for an operand that never goes through the datapath.
  function automatic logic [31:0] bypass_value(input fp_class_e cls);
    logic [31:0] v;
    case (cls)
      CLS_TO_PINF: v = FP_PINF;
      CLS_TO_QNAN: v = FP_QNAN;
      default:     v = FP_ZERO;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/newton_iter_ctrl_if.sv
// Operand-in / result-out handshake bundle of the Newton iteration controller.
// A transfer happens on the rising edge where valid && ready are both high; the
// sender holds valid and payload stable until that edge and valid never waits on ready.
interface newton_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;

  modport master (
    output in_valid, in_x, in_y0, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, in_y0, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/newton_iter_ctrl_fp_classify_half.sv
// Combinational operand classifier: decides whether x skips the Newton datapath
// and produces x/2 by decrementing the exponent field.
module fp_classify_half
  import fisr_pkg::*;
(
  input  logic [31:0] x,
  output fp_class_e   cls,
  output logic [31:0] x_half
);
  logic       sign;
  logic [7:0] expo;
  logic [22:0] man;

  always_comb begin
    sign = x[31];
    expo = x[30:23];
    man  = x[22:0];

    cls = CLS_NORMAL;
    if (expo == 8'hFF) begin
      cls = (man == 23'd0 && !sign) ? CLS_TO_ZERO : CLS_TO_QNAN;
    end else if (expo == 8'd0 && man == 23'd0) begin
      cls = CLS_TO_PINF;
    end else if (sign) begin
      cls = CLS_TO_QNAN;
    end else if (expo == 8'd0) begin
      cls = CLS_TO_PINF;
    end

    // Halving the smallest normal would need a denormal; flush it to zero instead.
    x_half = (expo == 8'd1) ? 32'h0 : {sign, expo - 8'd1, man};
  end
endmodule

// File: rtl/newton_iter_ctrl.sv
// Sequences ITERS Newton-Raphson refinements of an initial 1/sqrt(x) estimate
// through an external fixed-latency datapath, one operand at a time.
module newton_iter_ctrl
  import fisr_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int ITERS    = DEF_ITERS
) (
  input  logic                 clk,
  input  logic                 rst,
  newton_iter_ctrl_if.slave    bus,
  output logic [31:0]          dp_in1,
  output logic [31:0]          dp_in2,
  input  logic [31:0]          dp_out,
  output logic                 busy,
  output state_e               state_dbg
);
  localparam logic [3:0] WAIT_LOAD = 4'(PIPE_LAT - 1);
  localparam logic [2:0] ITER_LAST = 3'(ITERS);

  state_e      state_q, state_d;
  logic [31:0] x_half_q, x_half_d;
  logic [31:0] y_q, y_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  iter_cnt_q, iter_cnt_d;

  fp_class_e   in_cls;
  logic [31:0] in_x_half;

  fp_classify_half u_classify (
    .x      (bus.in_x),
    .cls    (in_cls),
    .x_half (in_x_half)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_half_q   <= '0;
      y_q        <= '0;
      wait_cnt_q <= '0;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_half_q   <= x_half_d;
      y_q        <= y_d;
      wait_cnt_q <= wait_cnt_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = (in_cls == CLS_NORMAL) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_cnt_q == 4'd0)
                  state_d = (iter_cnt_q + 3'd1 == ITER_LAST) ? ST_DONE : ST_ISSUE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // dp_out is only trusted in the last WAIT cycle; anything else in the pipe is stale.
  always_comb begin
    x_half_d   = x_half_q;
    y_d        = y_q;
    wait_cnt_d = wait_cnt_q;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_half_d   = in_x_half;
          y_d        = (in_cls == CLS_NORMAL) ? bus.in_y0 : bypass_value(in_cls);
          iter_cnt_d = 3'd0;
        end
      end
      ST_ISSUE: wait_cnt_d = WAIT_LOAD;
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          y_d        = dp_out;
          iter_cnt_d = iter_cnt_q + 3'd1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    busy          = (state_q != ST_IDLE);
  end

  assign bus.out_y  = y_q;
  assign dp_in1     = x_half_q;
  assign dp_in2     = y_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_newton_iter_ctrl.sv
// Bench for newton_iter_ctrl: float-level datapath model, real-arithmetic reference,
// scoreboard queues fed at operand acceptance and drained by a negedge monitor.
module tb_newton_iter_ctrl;
  import fisr_pkg::*;

  localparam int LAT = DEF_PIPE_LAT;
  localparam int NIT = DEF_ITERS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (defaults) ----------------
  newton_iter_ctrl_if bif ();
  logic [31:0] dp_in1, dp_in2, dp_out;
  logic        busy;
  state_e      state_dbg;

  newton_iter_ctrl #(.PIPE_LAT(LAT), .ITERS(NIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .dp_in1    (dp_in1),
    .dp_in2    (dp_in2),
    .dp_out    (dp_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- DUT (ITERS=1, PIPE_LAT=1) ----------------
  newton_iter_ctrl_if bif2 ();
  logic [31:0] dp2_in1, dp2_in2, dp2_out;
  logic        busy2;
  state_e      state_dbg2;

  newton_iter_ctrl #(.PIPE_LAT(1), .ITERS(1)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif2),
    .dp_in1    (dp2_in1),
    .dp_in2    (dp2_in2),
    .dp_out    (dp2_out),
    .busy      (busy2),
    .state_dbg (state_dbg2)
  );

  // ---------------- float helpers / reference ----------------
  function automatic real f2r(input logic [31:0] b);
    real p;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    p = 1.0;
    for (int i = 127; i < e; i++) p = p * 2.0;
    for (int i = e; i < 127; i++) p = p / 2.0;
    p = p * (1.0 + real'(b[22:0]) / 8388608.0);
    return b[31] ? -p : p;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'h0};
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] newton_step(input logic [31:0] xh, input logic [31:0] y);
    real yr;
    yr = f2r(y);
    return r2f(yr * (1.5 - f2r(xh) * yr * yr));
  endfunction

  function automatic logic [31:0] ref_xh(input logic [31:0] x);
    return r2f(f2r(x) * 0.5);
  endfunction

  function automatic bit is_bypass(input logic [31:0] x);
    return x[31] || x[30:23] == 8'hFF || x[30:23] == 8'h00;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [31:0] y0, input int iters);
    logic [31:0] y;
    if (x[30:0] == 31'h0) return FP_PINF;
    if (x == 32'h7F80_0000) return FP_ZERO;
    if (x[30:23] == 8'hFF || x[31]) return FP_QNAN;
    if (x[30:23] == 8'h00) return FP_PINF;
    y = y0;
    for (int i = 0; i < iters; i++) y = newton_step(ref_xh(x), y);
    return y;
  endfunction

  // ---------------- datapath models ----------------
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= newton_step(dp_in1, dp_in2);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_out = pipe[LAT-1];

  always @(posedge clk) dp2_out <= newton_step(dp2_in1, dp2_in2);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  logic [31:0] exp_q[$];
  int          rise_q[$];
  bit          inflight  = 1'b0;
  bit          hold_prev = 1'b0;
  bit          issue_chk = 1'b0;
  logic [31:0] issue_xh, issue_y0;
  int          last_hand = 0;
  int          last_gap  = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      rise_q.delete();
      inflight  = 1'b0;
      hold_prev = 1'b0;
      issue_chk = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(inflight));
      chk("in_ready", 32'(bif.in_ready), 32'(!inflight));
      if (issue_chk) begin
        chk("dp_in1", dp_in1, issue_xh);
        chk("dp_in2", dp_in2, issue_y0);
        issue_chk = 1'b0;
      end
      if (bif.out_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else begin
          if (!hold_prev) chk("latency", cyc, rise_q[0]);
          chk("out_y", bif.out_y, exp_q[0]);
        end
      end else if (rise_q.size() != 0 && cyc == rise_q[0]) begin
        fail_now("out_valid_late");
      end
      hold_prev = bif.out_valid && !bif.out_ready;
      if (bif.out_valid && bif.out_ready) begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(rise_q.pop_front());
        end
        inflight  = 1'b0;
        last_hand = cyc;
      end
      if (bif.in_valid && bif.in_ready) begin
        exp_q.push_back(ref_result(bif.in_x, bif.in_y0, NIT));
        rise_q.push_back(cyc + (is_bypass(bif.in_x) ? 1 : NIT * (LAT + 1) + 1));
        if (!is_bypass(bif.in_x)) begin
          issue_chk = 1'b1;
          issue_xh  = ref_xh(bif.in_x);
          issue_y0  = bif.in_y0;
        end
        inflight = 1'b1;
        last_gap = cyc - last_hand;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] x, input logic [31:0] y0, input bit hold);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_x     = x;
    bif.in_y0    = y0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bif.in_ready;
      n++;
    end
    if (!acc) fail_now("send_timeout");
    @(posedge clk); #1;
    if (!hold) bif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic pick(output logic [31:0] x, output logic [31:0] y0);
    int e;
    y0 = $urandom;
    if ($urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 8))
        0: x = 32'h0000_0000;
        1: x = 32'h8000_0000;
        2: x = 32'h7F80_0000;
        3: x = 32'hFF80_0000;
        4: x = 32'h7FC0_0001;
        5: x = 32'hBF80_0000;
        6: x = 32'h0000_0123;
        7: x = 32'h8000_0001;
        default: begin
          x  = 32'h0080_0000;
          y0 = 32'h5F37_59DF - (x >> 1);
        end
      endcase
    end else begin
      e  = $urandom_range(64, 190);
      x  = {1'b0, 8'(e), 23'($urandom)};
      y0 = 32'h5F37_59DF - (x >> 1);
    end
  endtask

  task automatic run_random(input int ncyc);
    bit          acc;
    logic [31:0] x, y0;
    acc = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (acc) bif.in_valid = 1'b0;
      if (!bif.in_valid && $urandom_range(0, 2) == 0) begin
        pick(x, y0);
        bif.in_x     = x;
        bif.in_y0    = y0;
        bif.in_valid = 1'b1;
      end
      bif.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bif.in_valid && bif.in_ready;
      @(posedge clk); #1;
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic run_iter1(input logic [31:0] x, input logic [31:0] y0);
    bif2.in_valid = 1'b1;
    bif2.in_x     = x;
    bif2.in_y0    = y0;
    @(negedge clk);
    chk("it1_accept", 32'(bif2.in_ready), 32'd1);
    @(posedge clk); #1;
    bif2.in_valid = 1'b0;
    @(negedge clk);
    chk("it1_valid_c1", 32'(bif2.out_valid), 32'd0);
    @(negedge clk);
    chk("it1_valid_c2", 32'(bif2.out_valid), 32'd0);
    @(negedge clk);
    chk("it1_valid_c3", 32'(bif2.out_valid), 32'd1);
    chk("it1_out_y", bif2.out_y, ref_result(x, y0, 1));
    @(negedge clk);
    chk("it1_after", 32'(bif2.out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  int n;

  initial begin
    bif.in_valid   = 1'b0;
    bif.in_x       = '0;
    bif.in_y0      = '0;
    bif.out_ready  = 1'b1;
    bif2.in_valid  = 1'b0;
    bif2.in_x      = '0;
    bif2.in_y0     = '0;
    bif2.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_y", bif.out_y, 32'h0);
    chk("rst_dp_in1", dp_in1, 32'h0);
    chk("rst_dp_in2", dp_in2, 32'h0);
    chk("rst2_in_ready", 32'(bif2.in_ready), 32'd1);
    @(posedge clk); #1;

    // exact operand 4.0
    send(32'h4080_0000, 32'h3F00_0000, 1'b0);
    wait_idle();

    // bypass operands
    send(32'hBF80_0000, 32'h1234_5678, 1'b0);
    send(32'h0000_0000, 32'h1234_5678, 1'b0);
    send(32'h7F80_0000, 32'h1234_5678, 1'b0);
    wait_idle();

    // backpressure in DONE
    bif.out_ready = 1'b0;
    send(32'h4080_0000, 32'h3F00_0000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.out_valid && n < 50);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 32'(bif.out_valid), 32'd1);
      chk("bp_out_y", bif.out_y, 32'h3F00_0000);
      chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_valid", 32'(bif.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_after_valid", 32'(bif.out_valid), 32'd0);
    chk("bp_after_ready", 32'(bif.in_ready), 32'd1);
    @(posedge clk); #1;

    // reset in the middle of the first iteration's WAIT
    send(32'h4080_0000, 32'h3F00_0000, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_state", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(bif.out_valid), 32'd0);
    @(posedge clk); #1;
    send(32'h4180_0000, 32'h3E80_0000, 1'b0);
    wait_idle();

    // back-to-back with in_valid held high
    send(32'h4080_0000, 32'h3F00_0000, 1'b1);
    send(32'h4180_0000, 32'h3E80_0000, 1'b0);
    chk("b2b_accept_gap", last_gap, 32'd1);
    wait_idle();

    // single-iteration, single-cycle-latency instance
    run_iter1(32'h4080_0000, 32'h3F00_0000);
    run_iter1(32'h4040_0000, 32'h5F37_59DF - (32'h4040_0000 >> 1));

    // randomized traffic
    run_random(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/newton_iter_ctrl.md
NEWTON_ITER_CTRL -- requirements
Module: newton_iter_ctrl

Interface
REQ-001 Parameter PIPE_LAT, 4: clock edges from the datapath sampling dp_in1/dp_in2 to dp_out holding the matching result; legal 1..15.
REQ-002 Parameter ITERS, 2: Newton iterations per operand; legal 1..4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  controller accepts an operand this cycle.
REQ-007 in_x  input  32  IEEE-754 single-precision x.
REQ-008 in_y0  input  32  initial estimate y0 from the magic-constant stage.
REQ-009 dp_in1  output  32  x/2 to the Newton datapath.
REQ-010 dp_in2  output  32  current y to the Newton datapath.
REQ-011 dp_out  input  32  datapath result y*(1.5 - x/2*y*y).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_y  output  32  final 1/sqrt(x).
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-017 IDLE: in_ready=1. On in_valid, the FSM latches x_half and y=in_y0, clears the iteration counter and goes to ISSUE. If the bypass of REQ-022 applies, it goes to DONE instead.
REQ-018 ISSUE lasts exactly one cycle. It loads the wait counter with PIPE_LAT-1 and goes to WAIT.
REQ-019 WAIT decrements the counter each cycle. In the cycle the counter reaches zero, the FSM captures dp_out into y and increments the iteration counter. It then goes to DONE if the counter now equals ITERS, and to ISSUE otherwise.
REQ-020 DONE: out_valid=1 and out_y=y, both stable until out_valid && out_ready. The FSM then returns to IDLE. in_ready=0 in DONE, so a new operand is not accepted in the same cycle as the result handoff.
REQ-021 dp_in1/dp_in2 SHALL be driven continuously from the x_half/y registers. dp_out SHALL be ignored in every cycle except the capture cycle of REQ-019.
REQ-022 Bypass: the datapath is skipped and out_y is forced as follows.
  - x=+0 or -0 -> 0x7F800000.
  - x=+inf -> 0x00000000.
  - x NaN, or x negative nonzero -> 0x7FC00000.
  - +denormal x -> 0x7F800000.
REQ-023 x_half SHALL equal x with the exponent decremented by 1. It SHALL be 0x00000000 when the exponent field is 1.
REQ-024 Normal latency: with the acceptance cycle counted as 0, out_valid SHALL first rise in cycle ITERS*(PIPE_LAT+1)+1. Bypass latency: out_valid SHALL rise in cycle 1.
REQ-025 Throughput SHALL be one operand in flight; operands are never interleaved.
REQ-026 Back-to-back operation: a new operand SHALL be accepted no earlier than the cycle after the handoff.

Reset
REQ-027 When rst=1 in any state, including mid-WAIT, the next state SHALL be IDLE.
REQ-028 Reset values: in_ready=1, out_valid=0, busy=0, out_y=0, dp_in1=0, dp_in2=0, both counters=0.
REQ-029 In-flight datapath results SHALL be discarded after reset and never presented on out_y.

Structure
REQ-030 Package fisr_pkg SHALL hold:
  - the FSM state enum;
  - float constants FP_QNAN=0x7FC00000, FP_PINF=0x7F800000, FP_ZERO=0x00000000 and FP_THREE_HALVES=0x3FC00000;
  - default PIPE_LAT and ITERS.
REQ-031 One combinational sub-module, fp_classify_half, SHALL produce the bypass class and x_half from in_x.

Verification
REQ-032 Exact operand: in_x=0x40800000 (4.0), in_y0=0x3F000000, defaults.
  - dp_in1 SHALL be 0x40000000.
  - out_y SHALL be 0x3F000000, with out_valid first high in cycle 11.
REQ-033 Bypass: in_x=0xBF800000 -> out_y=0x7FC00000 in cycle 1; in_x=0x00000000 -> out_y=0x7F800000; in_x=0x7F800000 -> out_y=0x00000000.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_y/out_valid SHALL stay stable.
  - in_ready SHALL stay 0.
  - The handoff SHALL occur on the first out_ready=1 cycle.
REQ-035 Reset mid-operation: assert rst for 1 cycle in WAIT of iteration 1.
  - The next cycle SHALL be IDLE with in_ready=1 and out_valid=0.
  - A following operand SHALL complete with the correct result at the normal latency.
REQ-036 Back-to-back: two operands, 4.0 then 0x41800000 (16.0, y0=0x3E800000), with in_valid held high.
  - Results SHALL be 0x3F000000 then 0x3E800000.
  - The second operand SHALL be accepted exactly one cycle after the first handoff.
REQ-037 Iteration count: ITERS=1, PIPE_LAT=1, in_x=0x40800000, in_y0=0x3F000000 -> out_valid in cycle 3 with exactly one dp_out capture.
